// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into instruction-memory words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [16:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic [15:0] len;
  logic [16:0] idx_nx;

  assign accept = byte_valid & byte_ready;
  assign len    = {len_hi, byte_data};
  assign idx_nx = idx + 17'd1;

  always_comb begin
    byte_ready = 1'b0;
    unique case (state)
      S_LEN_HI,
      S_LEN_LO,
      S_DATA:  byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:  byte_ready = 1'b1;
`endif
      default: byte_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      n_words   <= '0;
      idx       <= '0;
      bcnt      <= '0;
      shreg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE,
        S_DONE,
        S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            idx      <= '0;
            bcnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= byte_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            n_words <= len;
            if (len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else if ({1'b0, len} > MAX_N) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {shreg, byte_data};
              mem_addr  <= BASE_ADDR + {13'd0, idx, 2'b00};
              idx       <= idx_nx;
              bcnt      <= '0;
              if (idx_nx == {1'b0, n_words}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                state    <= S_DONE;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
`endif
              end
            end else begin
              shreg <= {shreg[15:0], byte_data};
              bcnt  <= bcnt + 2'd1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (byte_data == csum) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard.
// Optional checksum steps build when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  int w0;

  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      logic [63:0] e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%h:%h expected=none",
               mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({mem_addr, mem_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%h:%h expected=%h:%h",
                 mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] len, input int gap_max);
    logic [7:0]  cs;
    logic [31:0] w;
    bit          ok;
    cs = 8'h00;
    ok = ({1'b0, len} <= (17'(1) << ADDR_W));
    pulse_start();
    chk("hold_on_start", 32'(cpu_hold), 32'(1));
    chk("done_clr_start", 32'(done), 32'(0));
    send_byte(len[15:8], $urandom_range(gap_max, 0));
    send_byte(len[7:0], $urandom_range(gap_max, 0));
    if (ok) begin
      for (int i = 0; i < int'(len); i++) begin
        w = img[i];
        exp_q.push_back({BASE + 32'(4 * i), w});
        for (int k = 3; k >= 0; k--) begin
          send_byte(w[8*k +: 8], $urandom_range(gap_max, 0));
          cs ^= w[8*k +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`endif
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    img[0] = 32'h20080005;
    img[1] = 32'h01095020;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'(1));
    chk("rst_ready", 32'(byte_ready), 32'(0));
    chk("rst_addr", mem_addr, BASE);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_hold", 32'(cpu_hold), 32'(1));
    chk("idle_ready", 32'(byte_ready), 32'(0));
    chk("idle_we", 32'(mem_we), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_err", 32'(error), 32'(0));
    chk("idle_writes", 32'(wr_count), 32'(0));

    w0 = wr_count;
    load(16'd2, 0);
    chk("basic_writes", 32'(wr_count - w0), 32'(2));
    chk("basic_done", 32'(done), 32'(1));
    chk("basic_hold", 32'(cpu_hold), 32'(0));
    chk("basic_ready", 32'(byte_ready), 32'(0));

    // Bytes offered while DONE must not be consumed.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("done_hold_byte", 32'(done), 32'(1));
    chk("done_no_write", 32'(wr_count - w0), 32'(2));

    w0 = wr_count;
    load(16'd2, 3);
    chk("gap_writes", 32'(wr_count - w0), 32'(2));
    chk("gap_done", 32'(done), 32'(1));

    w0 = wr_count;
    load(16'd0, 0);
    chk("n0_writes", 32'(wr_count - w0), 32'(0));
    chk("n0_done", 32'(done), 32'(1));
    chk("n0_hold", 32'(cpu_hold), 32'(0));

    w0 = wr_count;
    load(16'h0101, 0);
    chk("big_writes", 32'(wr_count - w0), 32'(0));
    chk("big_err", 32'(error), 32'(1));
    chk("big_hold", 32'(cpu_hold), 32'(1));
    chk("big_ready", 32'(byte_ready), 32'(0));
    chk("big_done", 32'(done), 32'(0));

    w0 = wr_count;
    load(16'd1, 1);
    chk("recover_writes", 32'(wr_count - w0), 32'(1));
    chk("recover_done", 32'(done), 32'(1));
    chk("recover_err", 32'(error), 32'(0));

    w0 = wr_count;
    load(16'h0100, 0);
    chk("max_writes", 32'(wr_count - w0), 32'(256));
    chk("max_done", 32'(done), 32'(1));

    // A start pulse mid-word must not restart the session.
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({BASE, 32'h13579BDF});
    send_byte(8'h13, 0);
    send_byte(8'h57, 0);
    pulse_start();
    send_byte(8'h9B, 0);
    send_byte(8'hDF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h13 ^ 8'h57 ^ 8'h9B ^ 8'hDF, 0);
`endif
    repeat (2) @(negedge clk);
    chk("ign_start_writes", 32'(wr_count - w0), 32'(1));
    chk("ign_start_done", 32'(done), 32'(1));

    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_we", 32'(mem_we), 32'(0));
    chk("midrst_ready", 32'(byte_ready), 32'(0));
    chk("midrst_hold", 32'(cpu_hold), 32'(1));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_writes", 32'(wr_count - w0), 32'(0));
    chk("midrst_idle_ready", 32'(byte_ready), 32'(0));
    img[0] = 32'hCAFEF00D;
    load(16'd1, 0);
    chk("fresh_writes", 32'(wr_count - w0), 32'(1));
    chk("fresh_done", 32'(done), 32'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({BASE, 32'h11224488});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h44, 0);
    send_byte(8'h88, 0);
    chk("cs_pending", 32'(byte_ready), 32'(1));
    send_byte(8'hFF, 0);
    repeat (2) @(negedge clk);
    chk("cs_ok_done", 32'(done), 32'(1));
    chk("cs_ok_hold", 32'(cpu_hold), 32'(0));

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({BASE, 32'h11224488});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h44, 0);
    send_byte(8'h88, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("cs_bad_err", 32'(error), 32'(1));
    chk("cs_bad_hold", 32'(cpu_hold), 32'(1));
    chk("cs_bad_done", 32'(done), 32'(0));
    chk("cs_writes", 32'(wr_count - w0), 32'(2));
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
